// File: rtl/pixel_frame_pkg.sv
// Shared types and constants for the pixel frame receiver.
// PIXEL_FRAME_RX_CHECKSUM_EN adds the CHECK state for the trailing XOR byte.
package pixel_frame_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR_UNI,
    HDR_CNT_H,
    HDR_CNT_L,
    HDR_MODE,
    PAYLOAD,
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
    CHECK,
`endif
    COMMIT,
    DRAIN
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_UNIVERSE = 3'd1,
    ERR_COUNT    = 3'd2,
    ERR_ORDER    = 3'd3,
    ERR_ABORT    = 3'd4,
    ERR_CHECKSUM = 3'd5
  } err_code_t;

  // Wire order of the three colour bytes within a pixel.
  typedef enum logic [2:0] {
    ORD_RGB = 3'd0,
    ORD_RBG = 3'd1,
    ORD_GRB = 3'd2,
    ORD_GBR = 3'd3,
    ORD_BRG = 3'd4,
    ORD_BGR = 3'd5
  } order_t;

  localparam int unsigned MODE_ORDER_LSB = 0;
  localparam int unsigned MODE_ORDER_W   = 3;
  localparam int unsigned MODE_W_EN_BIT  = 3;

endpackage

// File: rtl/pixel_order_mux.sv
// Maps three received colour bytes to R, G and B according to the order code.
module pixel_order_mux
  import pixel_frame_pkg::*;
(
  input  logic [2:0] order,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  always_comb begin
    red   = byte0;
    green = byte1;
    blue  = byte2;
    case (order)
      ORD_RBG: begin red = byte0; blue  = byte1; green = byte2; end
      ORD_GRB: begin green = byte0; red = byte1; blue  = byte2; end
      ORD_GBR: begin green = byte0; blue = byte1; red  = byte2; end
      ORD_BRG: begin blue = byte0; red  = byte1; green = byte2; end
      ORD_BGR: begin blue = byte0; green = byte1; red  = byte2; end
      default: begin red = byte0; green = byte1; blue = byte2; end
    endcase
  end

endmodule

// File: rtl/pixel_frame_rx.sv
// Byte-stream frame receiver: decodes header, writes pixels to the back bank, commits by bank flip.
// Build option: PIXEL_FRAME_RX_CHECKSUM_EN enables the trailing XOR checksum byte.
module pixel_frame_rx
  import pixel_frame_pkg::*;
#(
  parameter  int unsigned NUM_UNIVERSES = 24,
  parameter  int unsigned MAX_PIXELS    = 512,
  localparam int unsigned UNI_W         = $clog2(NUM_UNIVERSES),
  localparam int unsigned ADDR_W        = $clog2(MAX_PIXELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_cs_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     wr_en,
  output logic [UNI_W-1:0]         wr_universe,
  output logic                     wr_bank,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [31:0]              wr_data,
  output logic                     commit_valid,
  output logic [UNI_W-1:0]         commit_universe,
  output logic [NUM_UNIVERSES-1:0] bank,
  output logic                     err_valid,
  output logic [2:0]               err_code,
  output logic                     busy
);

  state_t      state;
  logic        armed;
  logic [7:0]  uni_q;
  logic [15:0] cnt_q;
  logic [2:0]  order_q;
  logic        w_en_q;
  logic [1:0]  byte_cnt;
  logic [15:0] pix_cnt;
  logic [7:0]  byte0_q;
  logic [7:0]  byte1_q;
  logic [7:0]  byte2_q;
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  logic [UNI_W-1:0] uni_idx;
  logic             last_byte;
  logic [7:0]       byte2_mux;
  logic [7:0]       w_val;
  logic [7:0]       red;
  logic [7:0]       green;
  logic [7:0]       blue;
  logic [2:0]       mode_order;

  // The final byte of a pixel feeds the mux directly so the write can issue on that edge.
  always_comb begin
    uni_idx    = UNI_W'(uni_q);
    last_byte  = (byte_cnt == (w_en_q ? 2'd3 : 2'd2));
    byte2_mux  = w_en_q ? byte2_q : rx_data;
    w_val      = w_en_q ? rx_data : 8'h00;
    mode_order = rx_data[MODE_ORDER_LSB +: MODE_ORDER_W];
  end

  pixel_order_mux u_order_mux (
    .order (order_q),
    .byte0 (byte0_q),
    .byte1 (byte1_q),
    .byte2 (byte2_mux),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      armed           <= 1'b0;
      uni_q           <= 8'h00;
      cnt_q           <= 16'h0000;
      order_q         <= 3'd0;
      w_en_q          <= 1'b0;
      byte_cnt        <= 2'd0;
      pix_cnt         <= 16'h0000;
      byte0_q         <= 8'h00;
      byte1_q         <= 8'h00;
      byte2_q         <= 8'h00;
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
      xor_q           <= 8'h00;
`endif
      wr_en           <= 1'b0;
      wr_universe     <= '0;
      wr_bank         <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= 32'h0;
      commit_valid    <= 1'b0;
      commit_universe <= '0;
      bank            <= '0;
      err_valid       <= 1'b0;
      err_code        <= 3'd0;
      busy            <= 1'b0;
    end else begin
      wr_en        <= 1'b0;
      commit_valid <= 1'b0;
      err_valid    <= 1'b0;
      // A frame may only start after rx_cs_n has been seen high since reset.
      if (rx_cs_n) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (!rx_cs_n && armed) begin
            state    <= HDR_UNI;
            busy     <= 1'b1;
            byte_cnt <= 2'd0;
            pix_cnt  <= 16'h0000;
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
            xor_q    <= 8'h00;
`endif
          end
        end

        HDR_UNI: begin
          if (rx_cs_n) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            uni_q <= rx_data;
            state <= HDR_CNT_H;
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
            xor_q <= xor_q ^ rx_data;
`endif
          end
        end

`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
        HDR_CNT_H, HDR_CNT_L, HDR_MODE, PAYLOAD, CHECK: begin
`else
        HDR_CNT_H, HDR_CNT_L, HDR_MODE, PAYLOAD: begin
`endif
          if (rx_cs_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_ABORT;
          end else if (rx_valid) begin
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
            xor_q <= xor_q ^ rx_data;
`endif
            case (state)
              HDR_CNT_H: begin
                cnt_q[15:8] <= rx_data;
                state       <= HDR_CNT_L;
              end
              HDR_CNT_L: begin
                cnt_q[7:0] <= rx_data;
                state      <= HDR_MODE;
              end
              HDR_MODE: begin
                order_q <= mode_order;
                w_en_q  <= rx_data[MODE_W_EN_BIT];
                if (32'(uni_q) >= NUM_UNIVERSES) begin
                  state <= DRAIN; err_valid <= 1'b1; err_code <= ERR_UNIVERSE;
                end else if (cnt_q == 16'h0000 || 32'(cnt_q) > MAX_PIXELS) begin
                  state <= DRAIN; err_valid <= 1'b1; err_code <= ERR_COUNT;
                end else if (mode_order > 3'd5) begin
                  state <= DRAIN; err_valid <= 1'b1; err_code <= ERR_ORDER;
                end else begin
                  state <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                if (last_byte) begin
                  byte_cnt    <= 2'd0;
                  wr_en       <= 1'b1;
                  wr_universe <= uni_idx;
                  wr_bank     <= ~bank[uni_idx];
                  wr_addr     <= ADDR_W'(pix_cnt);
                  wr_data     <= {w_val, red, green, blue};
                  pix_cnt     <= pix_cnt + 16'd1;
                  if (pix_cnt == cnt_q - 16'd1) begin
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
                    state <= CHECK;
`else
                    state <= COMMIT;
`endif
                  end
                end else begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                    2'd0:    byte0_q <= rx_data;
                    2'd1:    byte1_q <= rx_data;
                    default: byte2_q <= rx_data;
                  endcase
                end
              end
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
              CHECK: begin
                if (rx_data == xor_q) begin
                  state <= COMMIT;
                end else begin
                  state     <= DRAIN;
                  err_valid <= 1'b1;
                  err_code  <= ERR_CHECKSUM;
                end
              end
`endif
              default: ;
            endcase
          end
        end

        COMMIT: begin
          bank[uni_idx]   <= ~bank[uni_idx];
          commit_valid    <= 1'b1;
          commit_universe <= uni_idx;
          state           <= DRAIN;
        end

        DRAIN: begin
          if (rx_cs_n) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_rx.sv
// Scoreboard bench for pixel_frame_rx; expected writes, commits and errors are queued as frames are driven.
module tb_pixel_frame_rx;

  localparam int unsigned NU     = 24;
  localparam int unsigned MP     = 512;
  localparam int unsigned UNI_W  = 5;
  localparam int unsigned ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_cs_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wr_en;
  logic [UNI_W-1:0]  wr_universe;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              commit_valid;
  logic [UNI_W-1:0]  commit_universe;
  logic [NU-1:0]     bank;
  logic              err_valid;
  logic [2:0]        err_code;
  logic              busy;

  pixel_frame_rx #(.NUM_UNIVERSES(NU), .MAX_PIXELS(MP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_cs_n         (rx_cs_n),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .wr_en           (wr_en),
    .wr_universe     (wr_universe),
    .wr_bank         (wr_bank),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .commit_valid    (commit_valid),
    .commit_universe (commit_universe),
    .bank            (bank),
    .err_valid       (err_valid),
    .err_code        (err_code),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [UNI_W-1:0]  uni;
    logic              bnk;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t              wr_q[$];
  logic [UNI_W-1:0] cm_uni_q[$];
  logic             cm_bank_q[$];
  logic [2:0]       err_q[$];
  logic [NU-1:0]    bank_m;
  wr_t              exp_wr;
  logic [UNI_W-1:0] exp_uni;
  logic             exp_bank;
  logic [2:0]       exp_err;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected pixel word from the bytes as they appear on the wire.
  function automatic logic [31:0] exp_pix(input logic [2:0] ord, input logic wen,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] w);
    logic [7:0] r, g, bl;
    case (ord)
      3'd0:    {r, g, bl} = {a, b, c};
      3'd1:    {r, bl, g} = {a, b, c};
      3'd2:    {g, r, bl} = {a, b, c};
      3'd3:    {g, bl, r} = {a, b, c};
      3'd4:    {bl, r, g} = {a, b, c};
      default: {bl, g, r} = {a, b, c};
    endcase
    return {(wen ? w : 8'h00), r, g, bl};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 32'(wr_en), 32'd0);
        else begin
          exp_wr = wr_q.pop_front();
          chk("wr_universe", 32'(wr_universe), 32'(exp_wr.uni));
          chk("wr_bank", 32'(wr_bank), 32'(exp_wr.bnk));
          chk("wr_addr", 32'(wr_addr), 32'(exp_wr.addr));
          chk("wr_data", wr_data, exp_wr.data);
        end
      end
      if (commit_valid) begin
        if (cm_uni_q.size() == 0) chk("commit_unexpected", 32'(commit_valid), 32'd0);
        else begin
          exp_uni  = cm_uni_q.pop_front();
          exp_bank = cm_bank_q.pop_front();
          chk("commit_universe", 32'(commit_universe), 32'(exp_uni));
          chk("commit_bank", 32'(bank[exp_uni]), 32'(exp_bank));
        end
      end
      if (err_valid) begin
        if (err_q.size() == 0) chk("err_unexpected", 32'(err_code), 32'd0);
        else begin
          exp_err = err_q.pop_front();
          chk("err_code", 32'(err_code), 32'(exp_err));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // nsend complete pixels; a short valid frame ends with an abort where the byte
  // that would finish the next pixel arrives together with rx_cs_n rising.
  task automatic frame(input logic [7:0] uni, input logic [15:0] cnt, input logic [7:0] mode,
                       input int nsend, input bit fixed, input bit bad_ck);
    logic [7:0] ck;
    logic [7:0] pb[4];
    logic [7:0] pix[$];
    logic [2:0] ecode;
    int         bpp;
    bpp   = mode[3] ? 4 : 3;
    ecode = 3'd0;
    if (32'(uni) >= NU) ecode = 3'd1;
    else if (cnt == 16'd0 || 32'(cnt) > MP) ecode = 3'd2;
    else if (mode[2:0] > 3'd5) ecode = 3'd3;

    ck = uni ^ cnt[15:8] ^ cnt[7:0] ^ mode;
    for (int p = 0; p < nsend; p++) begin
      for (int k = 0; k < 4; k++) begin
        pb[k] = fixed ? 8'(10 * (k + 1)) : 8'($urandom);
        if (k < bpp) pix.push_back(pb[k]);
        if (k < bpp) ck = ck ^ pb[k];
      end
      if (ecode == 3'd0)
        wr_q.push_back('{uni: UNI_W'(uni), bnk: ~bank_m[UNI_W'(uni)], addr: ADDR_W'(p),
                         data: exp_pix(mode[2:0], mode[3], pb[0], pb[1], pb[2], pb[3])});
    end
    if (ecode != 3'd0) err_q.push_back(ecode);
    else if (32'(nsend) < 32'(cnt)) err_q.push_back(3'd4);
    else begin
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
      if (bad_ck) err_q.push_back(3'd5);
      else begin
        bank_m[UNI_W'(uni)] = ~bank_m[UNI_W'(uni)];
        cm_uni_q.push_back(UNI_W'(uni));
        cm_bank_q.push_back(bank_m[UNI_W'(uni)]);
      end
`else
      bank_m[UNI_W'(uni)] = ~bank_m[UNI_W'(uni)];
      cm_uni_q.push_back(UNI_W'(uni));
      cm_bank_q.push_back(bank_m[UNI_W'(uni)]);
`endif
    end

    @(posedge clk); #1 rx_cs_n = 1'b0;
    send_byte(uni);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    send_byte(mode);
    foreach (pix[i]) send_byte(pix[i]);
    if (ecode == 3'd0 && 32'(nsend) < 32'(cnt)) begin
      for (int k = 0; k < bpp - 1; k++) send_byte(8'($urandom));
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      rx_cs_n  = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end else begin
`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
      if (ecode == 3'd0) send_byte(bad_ck ? (ck ^ 8'h5A) : ck);
`endif
      @(posedge clk); #1 rx_cs_n = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_cs_n  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    bank_m   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_commit", 32'(commit_valid), 32'd0);
    chk("rst_err", {28'd0, err_valid, err_code}, 32'd0);
    chk("rst_bank", 32'(bank), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // GRB reference frame
    frame(8'd2, 16'd3, 8'h02, 3, 1'b1, 1'b0);
    chk("bank2_after_commit", 32'(bank[2]), 32'd1);

    frame(8'd30, 16'd3, 8'h00, 2, 1'b0, 1'b0);
    frame(8'd4, 16'd512, 8'h08, 512, 1'b0, 1'b0);
    frame(8'd4, 16'd513, 8'h08, 1, 1'b0, 1'b0);
    frame(8'd6, 16'd0, 8'h00, 1, 1'b0, 1'b0);
    frame(8'd7, 16'd2, 8'h06, 1, 1'b0, 1'b0);

    for (int o = 0; o < 6; o++)
      for (int w = 0; w < 2; w++)
        frame(8'(o * 3 + w), 16'd2, {4'd0, 1'(w), 3'(o)}, 2, 1'b0, 1'b0);

    // abort after 2 of 4 pixels, then the same universe decodes normally
    frame(8'd5, 16'd4, 8'h00, 2, 1'b0, 1'b0);
    chk("bank5_after_abort", 32'(bank[5]), 32'(bank_m[5]));
    frame(8'd5, 16'd4, 8'h00, 4, 1'b0, 1'b0);
    frame(8'd23, 16'd1, 8'h0C, 1, 1'b0, 1'b0);

`ifdef PIXEL_FRAME_RX_CHECKSUM_EN
    frame(8'd9, 16'd2, 8'h01, 2, 1'b0, 1'b1);
    chk("bank9_after_bad_ck", 32'(bank[9]), 32'(bank_m[9]));
    frame(8'd9, 16'd2, 8'h01, 2, 1'b0, 1'b0);
`endif

    // reset asserted mid-payload
    wr_q.push_back('{uni: 5'd1, bnk: ~bank_m[1], addr: 9'd0, data: 32'h00010203});
    @(posedge clk); #1 rx_cs_n = 1'b0;
    send_byte(8'd1);
    send_byte(8'd0);
    send_byte(8'd4);
    send_byte(8'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h11);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_mid_frame", 32'(busy), 32'd1);
    chk("bank_before_reset", 32'(bank), 32'(bank_m));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_bank", 32'(bank), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", {28'd0, err_valid, err_code}, 32'd0);
    bank_m = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    // still inside the old frame: must not decode until rx_cs_n cycles
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    chk("busy_after_reset", 32'(busy), 32'd0);
    @(posedge clk); #1 rx_cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    frame(8'd1, 16'd2, 8'h0D, 2, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    chk("commit_q_left", 32'(cm_uni_q.size()), 32'd0);
    chk("err_q_left", 32'(err_q.size()), 32'd0);
    chk("bank_final", 32'(bank), 32'(bank_m));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_frame_rx.md
PIXEL_FRAME_RX -- requirements
Module: pixel_frame_rx

Interface
REQ-001 SHALL have parameter NUM_UNIVERSES, default 24, number of output strings.
REQ-002 SHALL have parameter MAX_PIXELS, default 512, maximum pixels per universe.
REQ-003 SHALL derive localparams UNI_W = $clog2(NUM_UNIVERSES) and ADDR_W = $clog2(MAX_PIXELS).
REQ-004 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_cs_n  input  1  frame delimiter; low means a frame is in progress.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe meaning rx_data holds a new byte.
REQ-008 SHALL have port rx_data  input  8  received byte.
REQ-009 SHALL have port wr_en  output  1  pixel write strobe.
REQ-010 SHALL have port wr_universe  output  UNI_W  target universe.
REQ-011 SHALL have port wr_bank  output  1  target buffer bank.
REQ-012 SHALL have port wr_addr  output  ADDR_W  pixel index.
REQ-013 SHALL have port wr_data  output  32  pixel value packed {W,R,G,B}.
REQ-014 SHALL have port commit_valid  output  1  one-cycle frame-complete pulse.
REQ-015 SHALL have port commit_universe  output  UNI_W  universe being committed.
REQ-016 SHALL have port bank  output  NUM_UNIVERSES  per-universe display bank.
REQ-017 SHALL have port err_valid  output  1  one-cycle error pulse.
REQ-018 SHALL have port err_code  output  3  error cause, valid with err_valid.
REQ-019 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-020 Frame layout SHALL be: universe byte, count_hi, count_lo, mode byte, then payload.
REQ-021 Mode byte SHALL be decoded as bits[2:0] order (0 RGB, 1 RBG, 2 GRB, 3 GBR, 4 BRG, 5 BGR) and bit[3] W_EN; bytes-per-pixel SHALL be 4 when W_EN=1, else 3.
REQ-022 FSM states SHALL be IDLE, HDR_UNI, HDR_CNT_H, HDR_CNT_L, HDR_MODE, PAYLOAD, CHECK, COMMIT, DRAIN.
REQ-023 IDLE SHALL go to HDR_UNI on rx_cs_n low; each header state SHALL advance once per rx_valid.
REQ-024 After HDR_MODE, the FSM SHALL validate in order and go to DRAIN with a single err_valid: universe >= NUM_UNIVERSES gives code 1; count of 0 or > MAX_PIXELS gives code 2; order > 5 gives code 3.
REQ-025 In PAYLOAD, bytes SHALL be assembled per pixel; the W byte, when enabled, is the last byte of the pixel.
REQ-026 wr_en SHALL pulse one cycle after the final byte of each pixel is accepted, with wr_addr = pixel index (starting at 0), wr_bank = ~bank[universe], and W = 0 when W_EN=0.
REQ-027 After pixel count-1 is written, the FSM SHALL go to COMMIT (or to CHECK when the checksum feature is compiled in).
REQ-028 COMMIT SHALL last one cycle, the cycle after the last wr_en: it toggles bank[universe], pulses commit_valid with commit_universe, then enters DRAIN.
REQ-029 DRAIN SHALL ignore all bytes until rx_cs_n is high, then go to IDLE.
REQ-030 rx_cs_n high in HDR_CNT_H..PAYLOAD or CHECK SHALL abort to IDLE with err_code 4 and no commit; if HDR_UNI sees rx_cs_n high with no byte received, the FSM SHALL return to IDLE silently.
REQ-031 If rx_cs_n high and rx_valid occur in the same cycle, rx_cs_n SHALL win and the byte SHALL be discarded.
REQ-032 Writes to bank ~bank[u] SHALL never change bank[u] unless a commit occurs; an aborted frame SHALL leave the displayed bank untouched.

Reset
REQ-033 On rst_n low, all of the following SHALL clear asynchronously: state=IDLE, wr_en=0, commit_valid=0, err_valid=0, err_code=0, wr_*=0, bank=0, busy=0, pixel/byte counters=0.
REQ-034 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for rx_cs_n high then low before decoding a new frame.

Configuration
REQ-035 With PIXEL_FRAME_RX_CHECKSUM_EN defined, one trailing byte SHALL equal the XOR of all header and payload bytes; CHECK SHALL compare it and go to COMMIT on match, or to DRAIN with err_code 5 and no commit on mismatch.
REQ-036 Without PIXEL_FRAME_RX_CHECKSUM_EN, the CHECK state and XOR register SHALL be absent and commit SHALL follow the last pixel directly.

Structure
REQ-037 Package pixel_frame_pkg SHALL hold the state enum, error-code constants (1..5), order-code constants and the mode-byte bit positions.
REQ-038 Sub-module pixel_order_mux SHALL combinationally map order code plus three captured bytes to R, G and B.

Verification
REQ-039 Universe 2, count 3, mode 0x02 (GRB), bytes 10,20,30 ×3 -> 3 wr_en with addr 0..2, wr_data 0x00140A1E, wr_bank 1; commit_valid for universe 2; bank[2]=1.
REQ-040 Universe 30 header (NUM_UNIVERSES=24) -> err_code 1, no wr_en, bytes ignored until rx_cs_n high.
REQ-041 Count 512, mode 0x08 (RGBW) -> 512 writes, last at addr 511 with W in [31:24]; count 513 -> err_code 2.
REQ-042 rx_cs_n rises after 2 of 4 pixels -> err_code 4, bank unchanged, next frame decodes normally.
REQ-043 Checksum build, wrong trailing byte -> err_code 5, no commit; correct byte -> commit.
REQ-044 rst_n pulsed mid-payload -> all outputs 0 immediately, bank=0.
